// File: rtl/gpu_ram_host_port_pkg.sv
// gpu_host_pkg: shared types and defaults for the GPU RAM host port.
// Holds the state encoding, default bus widths and the read latency
// counter helpers used by the host port and its interface.
package gpu_host_pkg;

    localparam int DEFAULT_ADDR_W       = 20;
    localparam int DEFAULT_DATA_W       = 8;
    localparam int DEFAULT_READ_LATENCY = 2;
    localparam int LAT_CNT_W            = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE_WR  = 2'd1,
        ISSUE_RD  = 2'd2,
        WAIT_DATA = 2'd3
    } gpu_host_state_t;

    // The counter is loaded one below the latency because the final
    // WAIT_DATA edge (count == 0) is the one that captures ram_rdata.
    function automatic logic [LAT_CNT_W-1:0] latency_load(input int latency);
        return LAT_CNT_W'(latency - 1);
    endfunction

endpackage

// File: rtl/gpu_ram_host_port_if.sv
// gpu_ram_host_port_if: bundles the bridge request/return signals, the
// RAM port signals and the status/control lines of the host port.
// "slave" is the host port itself; "master" is everything around it
// (bridge, video arbiter and RAM).
interface gpu_ram_host_port_if
    import gpu_host_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
);
    logic              host_wr_ena;
    logic              host_rd_req;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic [DATA_W-1:0] host_rd_data;
    logic              host_rd_rdy;
    logic              slot_busy;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_wr_ena;
    logic              ram_rd_ena;
    logic [DATA_W-1:0] ram_rdata;
    logic              busy;
    logic              overrun;
    logic              overrun_clr;

    modport master (
        output host_wr_ena, host_rd_req, host_addr, host_wdata,
        output slot_busy, ram_rdata, overrun_clr,
        input  host_rd_data, host_rd_rdy, ram_addr, ram_wdata,
        input  ram_wr_ena, ram_rd_ena, busy, overrun
    );

    modport slave (
        input  host_wr_ena, host_rd_req, host_addr, host_wdata,
        input  slot_busy, ram_rdata, overrun_clr,
        output host_rd_data, host_rd_rdy, ram_addr, ram_wdata,
        output ram_wr_ena, ram_rd_ena, busy, overrun
    );

endinterface

// File: rtl/gpu_ram_host_port_req_oneshot.sv
// req_oneshot: turns a request level from the bridge into a single-cycle
// pulse on its rising edge. The detector is disarmed until the first
// clock after reset release, so a level that was already high while in
// reset never produces a pulse.
module req_oneshot (
    input  logic GPU_CLK,
    input  logic reset_n,
    input  logic i_level,
    output logic o_pulse
);

    logic r_prev;
    logic r_armed;

    // Level history and arming flag for the edge detector.
    always_ff @(posedge GPU_CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_prev  <= i_level;
            r_armed <= 1'b1;
        end
    end

    assign o_pulse = i_level & ~r_prev & r_armed;

endmodule

// File: rtl/gpu_ram_host_port.sv
// gpu_ram_host_port: responder for host-bus RAM requests from the Z80
// bridge. One write and one read are buffered while the RAM port is
// owned by video fetch; writes are issued before reads so a read always
// observes an earlier write. Read data returns with a one-clock
// host_rd_rdy pulse after the RAM's fixed read latency.
module gpu_ram_host_port
    import gpu_host_pkg::*;
#(
    parameter int ADDR_W       = DEFAULT_ADDR_W,
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int READ_LATENCY = DEFAULT_READ_LATENCY
) (
    input  logic               GPU_CLK,
    input  logic               reset_n,
    gpu_ram_host_port_if.slave bus
);

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = latency_load(READ_LATENCY);

    gpu_host_state_t      r_state;
    gpu_host_state_t      w_next_state;

    logic                 w_wr_pulse;
    logic                 w_rd_pulse;
    logic                 w_wr_overrun;
    logic                 w_rd_overrun;
    logic                 w_data_due;

    logic                 r_wr_pend;
    logic [ADDR_W-1:0]    r_wr_addr;
    logic [DATA_W-1:0]    r_wr_data;
    logic                 r_rd_pend;
    logic [ADDR_W-1:0]    r_rd_addr;
    logic                 r_overrun;

    logic [ADDR_W-1:0]    r_ram_addr;
    logic [DATA_W-1:0]    r_ram_wdata;
    logic                 r_ram_wr_ena;
    logic                 r_ram_rd_ena;
    logic [LAT_CNT_W-1:0] r_lat_cnt;
    logic [DATA_W-1:0]    r_rd_data;
    logic                 r_rd_rdy;

    req_oneshot u_wr_oneshot (
        .GPU_CLK (GPU_CLK),
        .reset_n (reset_n),
        .i_level (bus.host_wr_ena),
        .o_pulse (w_wr_pulse)
    );

    req_oneshot u_rd_oneshot (
        .GPU_CLK (GPU_CLK),
        .reset_n (reset_n),
        .i_level (bus.host_rd_req),
        .o_pulse (w_rd_pulse)
    );

    // A new request whose holding register is still occupied is dropped.
    assign w_wr_overrun = w_wr_pulse & r_wr_pend;
    assign w_rd_overrun = w_rd_pulse & r_rd_pend;
    assign w_data_due   = (r_state == WAIT_DATA) && (r_lat_cnt == '0);

    // Write holding register: capture on a fresh request, release once issued.
    always_ff @(posedge GPU_CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_pend <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else if (w_wr_pulse && !r_wr_pend) begin
            r_wr_pend <= 1'b1;
            r_wr_addr <= bus.host_addr;
            r_wr_data <= bus.host_wdata;
        end else if (r_state == ISSUE_WR) begin
            r_wr_pend <= 1'b0;
        end
    end

    // Read holding register: capture on a fresh request, release once issued.
    always_ff @(posedge GPU_CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_pend <= 1'b0;
            r_rd_addr <= '0;
        end else if (w_rd_pulse && !r_rd_pend) begin
            r_rd_pend <= 1'b1;
            r_rd_addr <= bus.host_addr;
        end else if (r_state == ISSUE_RD) begin
            r_rd_pend <= 1'b0;
        end
    end

    // Sticky overrun flag; a new drop outranks a clear in the same cycle.
    always_ff @(posedge GPU_CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_overrun <= 1'b0;
        end else if (w_wr_overrun || w_rd_overrun) begin
            r_overrun <= 1'b1;
        end else if (bus.overrun_clr) begin
            r_overrun <= 1'b0;
        end
    end

    // State register.
    always_ff @(posedge GPU_CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: only IDLE may claim the port, and only when video leaves it free.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (r_wr_pend && !bus.slot_busy) begin
                    w_next_state = ISSUE_WR;
                end else if (r_rd_pend && !bus.slot_busy) begin
                    w_next_state = ISSUE_RD;
                end
            end
            ISSUE_WR:  w_next_state = IDLE;
            ISSUE_RD:  w_next_state = WAIT_DATA;
            WAIT_DATA: begin
                if (r_lat_cnt == '0) begin
                    w_next_state = IDLE;
                end
            end
            default:   w_next_state = IDLE;
        endcase
    end

    // RAM port drive: strobes are flops that are high exactly while in the issue states.
    always_ff @(posedge GPU_CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
            r_ram_wr_ena <= 1'b0;
            r_ram_rd_ena <= 1'b0;
        end else begin
            r_ram_wr_ena <= (w_next_state == ISSUE_WR);
            r_ram_rd_ena <= (w_next_state == ISSUE_RD);
            if (w_next_state == ISSUE_WR) begin
                r_ram_addr  <= r_wr_addr;
                r_ram_wdata <= r_wr_data;
            end else if (w_next_state == ISSUE_RD) begin
                r_ram_addr  <= r_rd_addr;
            end
        end
    end

    // Read latency countdown and data return; the slot does not stall the return.
    always_ff @(posedge GPU_CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_lat_cnt <= '0;
            r_rd_data <= '0;
            r_rd_rdy  <= 1'b0;
        end else begin
            r_rd_rdy <= 1'b0;
            if (r_state == ISSUE_RD) begin
                r_lat_cnt <= LAT_LOAD;
            end else if (w_data_due) begin
                r_rd_data <= bus.ram_rdata;
                r_rd_rdy  <= 1'b1;
            end else if (r_state == WAIT_DATA) begin
                r_lat_cnt <= r_lat_cnt - 1'b1;
            end
        end
    end

    assign bus.ram_addr     = r_ram_addr;
    assign bus.ram_wdata    = r_ram_wdata;
    assign bus.ram_wr_ena   = r_ram_wr_ena;
    assign bus.ram_rd_ena   = r_ram_rd_ena;
    assign bus.host_rd_data = r_rd_data;
    assign bus.host_rd_rdy  = r_rd_rdy;
    assign bus.overrun      = r_overrun;
    assign bus.busy         = r_wr_pend | r_rd_pend | (r_state != IDLE);

endmodule

// File: tb/tb_gpu_ram_host_port.sv
// tb_gpu_ram_host_port: directed scenarios plus randomized traffic for the
// GPU RAM host port. A latency-pipelined RAM model answers the port, and a
// transaction-scheduling reference model predicts every output each cycle.
module tb_gpu_ram_host_port;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 8;
    localparam int LAT    = 2;

    logic gpuClk = 1'b0;
    logic resetN = 1'b0;

    int checks = 0;
    int errors = 0;

    gpu_ram_host_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    gpu_ram_host_port #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .READ_LATENCY (LAT)
    ) dut (
        .GPU_CLK (gpuClk),
        .reset_n (resetN),
        .bus     (bus)
    );

    always #5 gpuClk = ~gpuClk;

    // Background contents of untouched RAM locations.
    function automatic logic [7:0] initVal(input logic [19:0] a);
        return a[7:0] ^ a[15:8] ^ {4'h0, a[19:16]} ^ 8'h5A;
    endfunction

    // ---------------- RAM model ----------------
    logic [7:0] ramMem [int];
    logic [7:0] ramPipe [LAT];

    function automatic logic [7:0] ramRead(input logic [19:0] a);
        if (ramMem.exists(int'(a))) return ramMem[int'(a)];
        return initVal(a);
    endfunction

    // Synchronous RAM: data sampled with ram_rd_ena emerges LAT edges later.
    always @(posedge gpuClk) begin
        logic [7:0] rdVal;
        rdVal = bus.ram_rd_ena ? ramRead(bus.ram_addr) : 8'hxx;
        for (int k = LAT - 1; k > 0; k--) ramPipe[k] <= ramPipe[k-1];
        ramPipe[0] <= rdVal;
        if (bus.ram_wr_ena) ramMem[int'(bus.ram_addr)] = bus.ram_wdata;
    end

    assign bus.ram_rdata = ramPipe[LAT-1];

    // ---------------- reference model ----------------
    logic [7:0]  refMem [int];
    int          cycle = 0;
    bit          mPrevWr, mPrevRd, mArmed;
    bit          mWrPend, mRdPend, mOverrun;
    logic [19:0] mWrAddr, mRdAddr, mRamAddr;
    logic [7:0]  mWrData, mRamWdata, mRdData, mPendRdData;
    bit          mWrEna, mRdEna, mRdy, mBusy;
    int          mFreeAt, mWrClearAt, mRdClearAt, mRdyEdge;

    function automatic logic [7:0] refRead(input logic [19:0] a);
        if (refMem.exists(int'(a))) return refMem[int'(a)];
        return initVal(a);
    endfunction

    task automatic modelReset();
        mPrevWr = 0; mPrevRd = 0; mArmed = 0;
        mWrPend = 0; mRdPend = 0; mOverrun = 0;
        mWrAddr = '0; mRdAddr = '0; mRamAddr = '0;
        mWrData = '0; mRamWdata = '0; mRdData = '0; mPendRdData = '0;
        mWrEna = 0; mRdEna = 0; mRdy = 0; mBusy = 0;
        mFreeAt = 0; mWrClearAt = -1; mRdClearAt = -1; mRdyEdge = -1;
    endtask

    // One clock edge of the port, in transaction terms: the port is free
    // again 2 edges after a write is granted and LAT+2 edges after a read.
    task automatic modelStep(input bit wr, input bit rd, input logic [19:0] addr,
                             input logic [7:0] wdata, input bit slotBusy, input bit clr);
        bit wrP, rdP, wrPre, rdPre;
        wrP = mArmed && wr && !mPrevWr;
        rdP = mArmed && rd && !mPrevRd;
        mPrevWr = wr; mPrevRd = rd; mArmed = 1;
        wrPre = mWrPend; rdPre = mRdPend;
        mWrEna = 0; mRdEna = 0; mRdy = 0;
        if (cycle >= mFreeAt && !slotBusy) begin
            if (wrPre) begin
                mWrEna = 1; mRamAddr = mWrAddr; mRamWdata = mWrData;
                refMem[int'(mWrAddr)] = mWrData;
                mWrClearAt = cycle + 1; mFreeAt = cycle + 2;
            end else if (rdPre) begin
                mRdEna = 1; mRamAddr = mRdAddr; mPendRdData = refRead(mRdAddr);
                mRdyEdge = cycle + 1 + LAT; mRdClearAt = cycle + 1; mFreeAt = cycle + 2 + LAT;
            end
        end
        if (cycle == mRdyEdge) begin mRdy = 1; mRdData = mPendRdData; end
        if (cycle == mWrClearAt) mWrPend = 0;
        if (cycle == mRdClearAt) mRdPend = 0;
        if (wrP && !wrPre) begin mWrPend = 1; mWrAddr = addr; mWrData = wdata; end
        if (rdP && !rdPre) begin mRdPend = 1; mRdAddr = addr; end
        if ((wrP && wrPre) || (rdP && rdPre)) mOverrun = 1;
        else if (clr) mOverrun = 0;
        mBusy = mWrPend || mRdPend || (cycle < mFreeAt - 1);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance the model on each rising edge and compare all outputs mid-cycle.
    initial begin
        modelReset();
        forever begin
            @(posedge gpuClk);
            cycle++;
            if (!resetN) modelReset();
            else modelStep(bus.host_wr_ena, bus.host_rd_req, bus.host_addr,
                           bus.host_wdata, bus.slot_busy, bus.overrun_clr);
            @(negedge gpuClk);
            checkOutput("host_rd_rdy",  32'(bus.host_rd_rdy),  32'(mRdy));
            checkOutput("host_rd_data", 32'(bus.host_rd_data), 32'(mRdData));
            checkOutput("ram_wr_ena",   32'(bus.ram_wr_ena),   32'(mWrEna));
            checkOutput("ram_rd_ena",   32'(bus.ram_rd_ena),   32'(mRdEna));
            checkOutput("ram_addr",     32'(bus.ram_addr),     32'(mRamAddr));
            checkOutput("ram_wdata",    32'(bus.ram_wdata),    32'(mRamWdata));
            checkOutput("busy",         32'(bus.busy),         32'(mBusy));
            checkOutput("overrun",      32'(bus.overrun),      32'(mOverrun));
        end
    end

    // ---------------- stimulus ----------------
    int          firstWr, firstRd, firstRdy, wrCnt, rdCnt, rdyCnt;
    logic [19:0] rdAddrSeen;
    logic [7:0]  rdyData;

    task automatic resetDut();
        bus.host_wr_ena = 0; bus.host_rd_req = 0;
        bus.slot_busy = 0; bus.overrun_clr = 0;
        @(negedge gpuClk); #1 resetN = 0;
        repeat (2) @(negedge gpuClk);
        #1 resetN = 1;
        repeat (2) @(negedge gpuClk);
    endtask

    // Drives request/slot levels from bit masks (bit i = level during cycle i,
    // starting at the current falling edge) and records when strobes and
    // returns are seen, relative to that starting edge.
    task automatic applyStimulus(input int n, input logic [31:0] wrMask,
                                 input logic [31:0] rdMask, input logic [31:0] busyMask);
        firstWr = -1; firstRd = -1; firstRdy = -1;
        wrCnt = 0; rdCnt = 0; rdyCnt = 0;
        rdAddrSeen = '0; rdyData = '0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                @(negedge gpuClk);
                if (bus.ram_wr_ena) begin
                    wrCnt++;
                    if (firstWr < 0) firstWr = i;
                end
                if (bus.ram_rd_ena) begin
                    rdCnt++;
                    if (firstRd < 0) begin firstRd = i; rdAddrSeen = bus.ram_addr; end
                end
                if (bus.host_rd_rdy) begin
                    rdyCnt++;
                    if (firstRdy < 0) begin firstRdy = i; rdyData = bus.host_rd_data; end
                end
            end
            bus.host_wr_ena = (i < 32) ? wrMask[i]   : 1'b0;
            bus.host_rd_req = (i < 32) ? rdMask[i]   : 1'b0;
            bus.slot_busy   = (i < 32) ? busyMask[i] : 1'b0;
        end
    endtask

    initial begin
        ramMem[32'h12345] = 8'hA5;
        refMem[32'h12345] = 8'hA5;
        bus.host_wr_ena = 0; bus.host_rd_req = 0; bus.host_addr = '0;
        bus.host_wdata = '0; bus.slot_busy = 0; bus.overrun_clr = 0;
        resetN = 0;
        repeat (3) @(negedge gpuClk);
        checkOutput("reset_busy",     32'(bus.busy),        32'd0);
        checkOutput("reset_rd_rdy",   32'(bus.host_rd_rdy), 32'd0);
        #1 resetN = 1;
        repeat (2) @(negedge gpuClk);

        // Single read, free slot.
        $display("[TB] single read");
        bus.host_addr = 20'h12345;
        applyStimulus(12, 32'h0, 32'h1, 32'h0);
        checkOutput("t1_rd_strobe_cycle", 32'(firstRd),    32'd2);
        checkOutput("t1_rd_strobe_addr",  32'(rdAddrSeen), 32'h12345);
        checkOutput("t1_rd_strobe_count", 32'(rdCnt),      32'd1);
        checkOutput("t1_rdy_cycle",       32'(firstRdy),   32'd5);
        checkOutput("t1_rdy_data",        32'(rdyData),    32'hA5);
        checkOutput("t1_rdy_count",       32'(rdyCnt),     32'd1);

        // Write then read-after-write to the same location.
        $display("[TB] write then read");
        resetDut();
        bus.host_addr = 20'h00010; bus.host_wdata = 8'h3C;
        applyStimulus(14, 32'h1, 32'h4, 32'h0);
        checkOutput("t2_wr_strobe_cycle", 32'(firstWr),  32'd2);
        checkOutput("t2_rd_strobe_cycle", 32'(firstRd),  32'd4);
        checkOutput("t2_rdy_cycle",       32'(firstRdy), 32'd7);
        checkOutput("t2_rdy_data",        32'(rdyData),  32'h3C);

        // Video owns the slot for 5 clocks right after the request.
        $display("[TB] slot busy");
        resetDut();
        bus.host_addr = 20'h0ABCD;
        applyStimulus(16, 32'h0, 32'h1, 32'h3E);
        checkOutput("t3_rd_strobe_cycle", 32'(firstRd),  32'd7);
        checkOutput("t3_rdy_cycle",       32'(firstRdy), 32'd10);
        checkOutput("t3_rdy_data",        32'(rdyData),  32'(initVal(20'h0ABCD)));

        // Second read edge while the first is still held.
        $display("[TB] overrun");
        resetDut();
        bus.host_addr = 20'h00200;
        applyStimulus(14, 32'h0, 32'h5, 32'h0);
        checkOutput("t4_rd_strobe_count", 32'(rdCnt),       32'd1);
        checkOutput("t4_rdy_count",       32'(rdyCnt),      32'd1);
        checkOutput("t4_overrun_set",     32'(bus.overrun), 32'd1);
        bus.overrun_clr = 1;
        @(negedge gpuClk);
        bus.overrun_clr = 0;
        checkOutput("t4_overrun_cleared", 32'(bus.overrun), 32'd0);

        // Level held high is one request.
        $display("[TB] held request");
        resetDut();
        bus.host_addr = 20'h00300;
        applyStimulus(30, 32'h0, 32'h000F_FFFF, 32'h0);
        checkOutput("t5_rd_strobe_count", 32'(rdCnt),  32'd1);
        checkOutput("t5_rdy_count",       32'(rdyCnt), 32'd1);

        // Reset while waiting for read data.
        $display("[TB] reset mid-read");
        resetDut();
        bus.host_addr = 20'h00777;
        applyStimulus(4, 32'h0, 32'h1, 32'h0);
        checkOutput("t6_rd_strobe_cycle", 32'(firstRd), 32'd2);
        #1 resetN = 0;
        #1;
        checkOutput("t6_rst_busy",     32'(bus.busy),         32'd0);
        checkOutput("t6_rst_ram_addr", 32'(bus.ram_addr),     32'd0);
        checkOutput("t6_rst_rd_ena",   32'(bus.ram_rd_ena),   32'd0);
        checkOutput("t6_rst_rd_rdy",   32'(bus.host_rd_rdy),  32'd0);
        repeat (2) @(negedge gpuClk);
        #1 resetN = 1;
        repeat (2) @(negedge gpuClk);
        applyStimulus(10, 32'h0, 32'h0, 32'h0);
        checkOutput("t6_no_stale_rdy", 32'(rdyCnt), 32'd0);
        applyStimulus(12, 32'h0, 32'h1, 32'h0);
        checkOutput("t6_rdy_cycle", 32'(firstRdy), 32'd5);
        checkOutput("t6_rdy_data",  32'(rdyData),  32'h2A);

        // Randomized traffic over a small address pool to provoke RAW hits.
        $display("[TB] random traffic");
        resetDut();
        for (int i = 0; i < 1500; i++) begin
            if (bus.host_wr_ena) bus.host_wr_ena = ($urandom_range(0, 2) != 0);
            else                 bus.host_wr_ena = ($urandom_range(0, 7) == 0);
            if (bus.host_rd_req) bus.host_rd_req = ($urandom_range(0, 2) != 0);
            else                 bus.host_rd_req = ($urandom_range(0, 6) == 0);
            bus.host_addr   = {2'b00, 2'($urandom_range(0, 3)), 13'h0, 3'($urandom_range(0, 7))};
            bus.host_wdata  = 8'($urandom);
            bus.slot_busy   = ($urandom_range(0, 9) < 3);
            bus.overrun_clr = ($urandom_range(0, 15) == 0);
            @(negedge gpuClk);
        end
        bus.host_wr_ena = 0; bus.host_rd_req = 0; bus.slot_busy = 0; bus.overrun_clr = 0;
        repeat (12) @(negedge gpuClk);
        checkOutput("final_idle_busy", 32'(bus.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop if the run ever stalls.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
